// File: rtl/writeback_arbiter_pkg.sv
// Shared definitions for the write-back collector: source indices and the result entry layout.
package writeback_arbiter_pkg;

    // Number of functional units feeding the write-back stage.
    localparam int WB_NUM_SRC = 3;

    typedef logic [1:0] wb_src_t;

    localparam wb_src_t WB_SRC_ALU = 2'd0;
    localparam wb_src_t WB_SRC_LSU = 2'd1;
    localparam wb_src_t WB_SRC_MDU = 2'd2;

    // One queued result: destination register and value.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    localparam int unsigned WB_ENTRY_W = 37;

    // Round-robin successor, wrapping MDU back to ALU.
    function automatic wb_src_t wb_next_src(input wb_src_t src);
        return (src == WB_SRC_MDU) ? WB_SRC_ALU : wb_src_t'(src + 2'd1);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small per-source result FIFO with a registered occupancy count.
module wb_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 37
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Guard the strobes so a misbehaving caller cannot corrupt the count.
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        full    = (count == DEPTH_CNT);
        empty   = (count == '0);
        dout    = mem[rd_ptr];
    end

    // Entry storage; contents are don't-care while the slot is empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Collects ALU/LSU/MDU results into per-source FIFOs and retires one per cycle, round-robin,
// as a registered register-file write pulse.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,

    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_ready_o,

    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_data_i,
    output logic        mdu_ready_o,

    output logic        reg_write_wb_o,
    output logic [4:0]  reg_rd_wb_o,
    output logic [31:0] reg_rd_data_wb_o,
    output logic        stall_wb_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    logic [WB_NUM_SRC-1:0] src_valid;
    logic [WB_NUM_SRC-1:0] src_ready;
    logic [WB_NUM_SRC-1:0] src_push;
    logic [WB_NUM_SRC-1:0] src_pop;
    logic [WB_NUM_SRC-1:0] src_full;
    logic [WB_NUM_SRC-1:0] src_empty;
    wb_entry_t             src_entry [WB_NUM_SRC];
    wb_entry_t             src_head  [WB_NUM_SRC];
    logic [CW-1:0]         src_count [WB_NUM_SRC];

    wb_src_t   last_grant;
    wb_src_t   grant_idx;
    logic      grant_valid;
    wb_entry_t head;

    assign src_valid = {mdu_valid_i, lsu_valid_i, alu_valid_i};
    assign src_entry[WB_SRC_ALU] = {alu_rd_i, alu_data_i};
    assign src_entry[WB_SRC_LSU] = {lsu_rd_i, lsu_data_i};
    assign src_entry[WB_SRC_MDU] = {mdu_rd_i, mdu_data_i};

    assign alu_ready_o = src_ready[WB_SRC_ALU];
    assign lsu_ready_o = src_ready[WB_SRC_LSU];
    assign mdu_ready_o = src_ready[WB_SRC_MDU];

    for (genvar s = 0; s < WB_NUM_SRC; s++) begin : g_src
        // Ready comes from the registered count only: a full FIFO refuses even while popping.
        assign src_ready[s] = (src_count[s] < DEPTH_CNT);
        assign src_push[s]  = src_valid[s] && src_ready[s];
        assign src_pop[s]   = grant_valid && (grant_idx == wb_src_t'(s));

        wb_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (WB_ENTRY_W)
        ) u_fifo (
            .clk   (clk_i),
            .rst_n (rst_i),
            .push  (src_push[s]),
            .pop   (src_pop[s]),
            .din   (src_entry[s]),
            .dout  (src_head[s]),
            .count (src_count[s]),
            .full  (src_full[s]),
            .empty (src_empty[s])
        );
    end

    assign stall_wb_o = |src_full;

    // Round-robin pick: first non-empty FIFO after the last grant, wrapping MDU to ALU.
    always_comb begin
        wb_src_t idx;
        idx         = last_grant;
        grant_valid = 1'b0;
        grant_idx   = last_grant;
        for (int i = 0; i < WB_NUM_SRC; i++) begin
            idx = wb_next_src(idx);
            if (!grant_valid && !src_empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
        head = src_head[grant_idx];
    end

    // Output register and grant pointer; an rd of x0 is retired silently without a strobe.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            reg_write_wb_o   <= 1'b0;
            reg_rd_wb_o      <= '0;
            reg_rd_data_wb_o <= '0;
            last_grant       <= WB_SRC_MDU;
        end else begin
            reg_write_wb_o <= grant_valid && (head.rd != '0);
            if (grant_valid) begin
                reg_rd_wb_o      <= head.rd;
                reg_rd_data_wb_o <= head.data;
                last_grant       <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random traffic against a
// queue-based reference model.
module tb_writeback_arbiter;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  vld;
    logic [4:0]  rd_in   [3];
    logic [31:0] data_in [3];

    logic        alu_ready, lsu_ready, mdu_ready;
    logic        wr, stall;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data;
    logic [2:0]  dut_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model: one queue of {rd,data} per source plus the last granted index.
    logic [36:0] m_q [3][$];
    int          m_last;
    logic        m_write;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    assign dut_ready = {mdu_ready, lsu_ready, alu_ready};

    always #5 clk = ~clk;

    writeback_arbiter #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_n),
        .alu_valid_i      (vld[0]),
        .alu_rd_i         (rd_in[0]),
        .alu_data_i       (data_in[0]),
        .alu_ready_o      (alu_ready),
        .lsu_valid_i      (vld[1]),
        .lsu_rd_i         (rd_in[1]),
        .lsu_data_i       (data_in[1]),
        .lsu_ready_o      (lsu_ready),
        .mdu_valid_i      (vld[2]),
        .mdu_rd_i         (rd_in[2]),
        .mdu_data_i       (data_in[2]),
        .mdu_ready_o      (mdu_ready),
        .reg_write_wb_o   (wr),
        .reg_rd_wb_o      (wr_rd),
        .reg_rd_data_wb_o (wr_data),
        .stall_wb_o       (stall)
    );

    function automatic logic [2:0] exp_ready();
        logic [2:0] r;
        for (int s = 0; s < 3; s++) r[s] = (m_q[s].size() < DEPTH);
        return r;
    endfunction

    function automatic logic exp_stall();
        logic st;
        st = 1'b0;
        for (int s = 0; s < 3; s++) if (m_q[s].size() == DEPTH) st = 1'b1;
        return st;
    endfunction

    task automatic model_clear();
        for (int s = 0; s < 3; s++) m_q[s].delete();
        m_last  = 2;
        m_write = 1'b0;
        m_rd    = '0;
        m_data  = '0;
    endtask

    // One clock: model decides from pre-edge state, then advances; returns #1 after the edge.
    task automatic step();
        logic [2:0]  acc;
        logic [36:0] hd;
        int          g;
        acc = '0;
        g   = -1;
        for (int s = 0; s < 3; s++) if (vld[s] && (m_q[s].size() < DEPTH)) acc[s] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            int s;
            s = (m_last + k) % 3;
            if (g < 0 && m_q[s].size() > 0) g = s;
        end
        @(posedge clk);
        if (g >= 0) begin
            hd      = m_q[g].pop_front();
            m_write = (hd[36:32] != 5'd0);
            m_rd    = hd[36:32];
            m_data  = hd[31:0];
            m_last  = g;
        end else begin
            m_write = 1'b0;
        end
        for (int s = 0; s < 3; s++) if (acc[s]) m_q[s].push_back({rd_in[s], data_in[s]});
        #1;
    endtask

    task automatic idle_inputs();
        vld = '0;
        for (int s = 0; s < 3; s++) begin
            rd_in[s]   = '0;
            data_in[s] = '0;
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({wr, wr_rd, wr_data, dut_ready, stall} !== {1'b0, 5'd0, 32'd0, 3'b111, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got wr=%b rd=%0d data=%h rdy=%b stall=%b want 0/0/0/111/0",
                     wr, wr_rd, wr_data, dut_ready, stall);
        end
    endtask

    task automatic test_single();
        logic [37:0] want [3];
        apply_reset();
        vld[0] = 1'b1; rd_in[0] = 5'd5; data_in[0] = 32'hDEAD_BEEF;
        want[0] = {1'b0, 5'd0, 32'd0};
        want[1] = {1'b1, 5'd5, 32'hDEAD_BEEF};
        want[2] = {1'b0, 5'd5, 32'hDEAD_BEEF};
        for (int c = 0; c < 3; c++) begin
            step();
            idle_inputs();
            checks++;
            if ({wr, wr_rd, wr_data} !== want[c]) begin
                failures++;
                $display("FAIL single_latency edge=%0d got %b/%0d/%h want %b/%0d/%h", c + 1,
                         wr, wr_rd, wr_data, want[c][37], want[c][36:32], want[c][31:0]);
            end
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        for (int burst = 0; burst < 2; burst++) begin
            vld = 3'b111;
            for (int s = 0; s < 3; s++) begin
                rd_in[s]   = 5'(s + 1);
                data_in[s] = $urandom;
            end
            step();
            idle_inputs();
            for (int c = 0; c < 3; c++) begin
                step();
                checks++;
                if (wr !== 1'b1 || wr_rd !== 5'(c + 1) || wr_data !== m_data) begin
                    failures++;
                    $display("FAIL simultaneous_order burst=%0d slot=%0d got wr=%b rd=%0d data=%h want wr=1 rd=%0d data=%h",
                             burst, c, wr, wr_rd, wr_data, c + 1, m_data);
                end
            end
        end
    endtask

    task automatic test_mdu_backpressure();
        int   sent;
        int   mdu_seen;
        logic saw_stall;
        logic adv;
        apply_reset();
        sent      = 0;
        mdu_seen  = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 16; c++) begin
            vld[0] = 1'b1; rd_in[0] = 5'($urandom_range(1, 15)); data_in[0] = $urandom;
            vld[2] = (sent < 3); rd_in[2] = 5'(20 + sent); data_in[2] = $urandom;
            adv = vld[2] && mdu_ready;
            step();
            if (adv) sent++;
            if (stall && !mdu_ready) saw_stall = 1'b1;
            if (wr && wr_rd >= 5'd20) mdu_seen++;
            checks++;
            if ({wr, wr_rd, wr_data, dut_ready, stall} !==
                {m_write, m_rd, m_data, exp_ready(), exp_stall()}) begin
                failures++;
                $display("FAIL mdu_backpressure cyc=%0d got wr=%b rd=%0d data=%h rdy=%b stall=%b want wr=%b rd=%0d data=%h rdy=%b stall=%b",
                         c, wr, wr_rd, wr_data, dut_ready, stall,
                         m_write, m_rd, m_data, exp_ready(), exp_stall());
            end
        end
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            step();
            if (wr && wr_rd >= 5'd20) mdu_seen++;
        end
        checks++;
        if (!saw_stall || mdu_seen != 3) begin
            failures++;
            $display("FAIL mdu_no_loss got stall_seen=%b mdu_retired=%0d want 1 and 3",
                     saw_stall, mdu_seen);
        end
    endtask

    task automatic test_rd_zero();
        apply_reset();
        vld = 3'b110;
        rd_in[1] = 5'd0; data_in[1] = 32'h0000_1234;
        rd_in[2] = 5'd9; data_in[2] = 32'hCAFE_0009;
        step();
        idle_inputs();
        step();
        checks++;
        if (wr !== 1'b0 || wr_rd !== 5'd0 || wr_data !== 32'h0000_1234) begin
            failures++;
            $display("FAIL rd_zero_silent got wr=%b rd=%0d data=%h want wr=0 rd=0 data=00001234",
                     wr, wr_rd, wr_data);
        end
        step();
        checks++;
        if (wr !== 1'b1 || wr_rd !== 5'd9 || wr_data !== 32'hCAFE_0009) begin
            failures++;
            $display("FAIL rd_zero_next got wr=%b rd=%0d data=%h want wr=1 rd=9 data=cafe0009",
                     wr, wr_rd, wr_data);
        end
    endtask

    task automatic test_full_alu();
        logic saw_full;
        apply_reset();
        saw_full = 1'b0;
        for (int c = 0; c < 14; c++) begin
            vld = 3'b111;
            for (int s = 0; s < 3; s++) begin
                rd_in[s]   = 5'($urandom_range(1, 31));
                data_in[s] = $urandom;
            end
            step();
            if (!alu_ready) saw_full = 1'b1;
            checks++;
            if ({wr, wr_rd, wr_data, dut_ready, stall} !==
                {m_write, m_rd, m_data, exp_ready(), exp_stall()}) begin
                failures++;
                $display("FAIL full_alu cyc=%0d got wr=%b rd=%0d data=%h rdy=%b stall=%b want wr=%b rd=%0d data=%h rdy=%b stall=%b",
                         c, wr, wr_rd, wr_data, dut_ready, stall,
                         m_write, m_rd, m_data, exp_ready(), exp_stall());
            end
        end
        idle_inputs();
        checks++;
        if (saw_full !== 1'b1) begin
            failures++;
            $display("FAIL full_alu_ready got saw_not_ready=%b want 1", saw_full);
        end
    endtask

    task automatic test_mid_reset();
        int strobes;
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            vld = 3'b111;
            for (int s = 0; s < 3; s++) begin
                rd_in[s]   = 5'($urandom_range(1, 31));
                data_in[s] = $urandom;
            end
            step();
        end
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wr, wr_rd, wr_data, dut_ready, stall} !== {1'b0, 5'd0, 32'd0, 3'b111, 1'b0}) begin
            failures++;
            $display("FAIL mid_reset_async got wr=%b rd=%0d data=%h rdy=%b stall=%b want 0/0/0/111/0",
                     wr, wr_rd, wr_data, dut_ready, stall);
        end
        @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;
        strobes = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (wr) strobes++;
        end
        checks++;
        if (strobes != 0 || dut_ready !== 3'b111) begin
            failures++;
            $display("FAIL mid_reset_drain got strobes=%0d rdy=%b want 0 and 111", strobes, dut_ready);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 3; s++) begin
                vld[s]     = ($urandom_range(0, 99) < 45);
                rd_in[s]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                data_in[s] = $urandom;
            end
            step();
            checks++;
            if ({wr, wr_rd, wr_data, dut_ready, stall} !==
                {m_write, m_rd, m_data, exp_ready(), exp_stall()}) begin
                failures++;
                $display("FAIL random cyc=%0d got wr=%b rd=%0d data=%h rdy=%b stall=%b want wr=%b rd=%0d data=%h rdy=%b stall=%b",
                         c, wr, wr_rd, wr_data, dut_ready, stall,
                         m_write, m_rd, m_data, exp_ready(), exp_stall());
            end
        end
        idle_inputs();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_clear();
        test_reset();
        test_single();
        test_simultaneous();
        test_mdu_backpressure();
        test_rd_zero();
        test_full_alu();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
